// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage of the 5-stage MIPS core.
// - fetch_state_e  : fetch FSM states (FETCH / WAIT / HOLD)
// - NopInstr       : bubble encoding, sll $0,$0,0
// - ResetPcDefault : default PC loaded at reset
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NopInstr       = 32'h0000_0000;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register.
// Owns the PC and fetches over a req/ready + rvalid handshake with one request in flight.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   StallF, StallD             hazard unit stalls (no new request / hold IF/ID)
//   id_branch_taken/_target    taken redirect resolved in ID
//   imem_req/addr/ready        request channel (accepted on req && ready)
//   imem_rvalid/rdata          response channel (one per accepted request)
//   if_id_instr/pc_plus4/valid IF/ID register contents
//   fetch_pending              high while waiting for a response
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(ResetPcDefault),
  parameter logic [31:0]        NOP_INSTR = NopInstr
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              id_branch_taken,
  input  logic [ADDR_W-1:0] id_branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              fetch_pending
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       hold_buf_q, hold_buf_d;
  // Set by reset, cleared by the first accepted request: a response left over from
  // before reset must never be taken as ours.
  logic              fresh_q, fresh_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;

  logic              deliver;
  logic [31:0]       deliver_word;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_aligned;
  logic              redirect;
  logic              req_fire;
  logic              resp;

  assign pc_plus4       = pc_q + ADDR_W'(4);
  assign target_aligned = id_branch_target & ~ADDR_W'(3);
  // A branch seen while ID is stalled is re-presented later, so ignore it now.
  assign redirect       = id_branch_taken && !StallD;
  assign req_fire       = imem_req && imem_ready;
  assign resp           = imem_rvalid && !fresh_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      hold_buf_q <= '0;
      fresh_q    <= 1'b1;
      instr_q    <= NOP_INSTR;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      hold_buf_q <= hold_buf_d;
      fresh_q    <= fresh_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_buf_d   = hold_buf_q;
    fresh_d      = fresh_q && !req_fire;
    deliver      = 1'b0;
    deliver_word = hold_buf_q;

    unique case (state_q)
      StFetch: begin
        if (req_fire) begin
          state_d = StWait;
          // Redirect in the acceptance cycle makes this request stale.
          drop_d  = redirect;
        end
      end
      StWait: begin
        if (resp) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = StFetch;
          end else if (!StallD) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            state_d      = StFetch;
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = StHold;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          hold_buf_d = '0;
          state_d    = StFetch;
        end else if (!StallD) begin
          deliver      = 1'b1;
          deliver_word = hold_buf_q;
          hold_buf_d   = '0;
          state_d      = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    if (redirect) begin
      pc_d = target_aligned;
    end else if (deliver) begin
      pc_d = pc_plus4;
    end

    // IF/ID: hold under StallD, otherwise load the delivered word or a bubble.
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!StallD) begin
      if (deliver) begin
        instr_d = deliver_word;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    imem_req      = rst_n && (state_q == StFetch) && !StallF;
    imem_addr     = pc_q;
    fetch_pending = (state_q == StWait);
  end

  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus, scoreboard of expected IF/ID
// deliveries popped by a monitor, and a variable-latency instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        StallD;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_pending;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  logic [63:0] exp_q[$];
  logic        stalld_seen = 1'b1;

  fetch_stage #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0000_0400),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .StallF           (StallF),
    .StallD           (StallD),
    .id_branch_taken  (id_branch_taken),
    .id_branch_target (id_branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .fetch_pending    (fetch_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x400 -> 0x2010_0001, 0x404 -> 0x2010_0005, 0x1000 -> 0x2010_1401 ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'h2010, a[15:0] ^ 16'h0401};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Instruction memory: response `lat` cycles after acceptance, one-cycle rvalid pulse.
  initial begin
    logic        acc;
    logic        pend;
    logic [31:0] acc_addr;
    logic [31:0] pend_addr;
    int          cnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    pend_addr   = '0;
    cnt         = 0;
    forever begin
      @(negedge clk);
      #4;
      acc      = imem_req && imem_ready;
      acc_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
        cnt       = lat;
        pend      = 1'b1;
        pend_addr = acc_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) stalld_seen <= StallD;

  // Monitor: every unstalled edge that leaves IF/ID valid is a new delivery.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_id_valid && !stalld_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got instr %h pc4 %h expected none",
                   if_id_instr, if_id_pc_plus4);
        end else begin
          e = exp_q.pop_front();
          check("delivery_instr", if_id_instr, e[63:32]);
          check("delivery_pc4", if_id_pc_plus4, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    StallF           = 1'b0;
    StallD           = 1'b0;
    id_branch_taken  = 1'b0;
    id_branch_target = '0;
    imem_ready       = 1'b1;
    #1;
    check("reset_req", imem_req, 0);
    check("reset_valid", if_id_valid, 0);
    check("reset_instr", if_id_instr, 32'h0);
    check("reset_pc4", if_id_pc_plus4, 32'h0);
    check("reset_pending", fetch_pending, 0);
    step();
    step();

    // First fetch after reset, single-cycle memory
    exp_q.push_back({32'h2010_0001, 32'h0000_0404});
    rst_n = 1'b1;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h400);
    step();
    check("first_wait_valid", if_id_valid, 0);
    check("first_wait_pending", fetch_pending, 1);
    step();
    check("first_delivered_valid", if_id_valid, 1);

    // Stall across the response: word parks in HOLD, IF/ID frozen
    exp_q.push_back({32'h2010_0005, 32'h0000_0408});
    lat = 3;
    step();
    StallF = 1'b1;
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", if_id_instr, 32'h0);
      check("stall_pc4", if_id_pc_plus4, 32'h404);
      check("stall_valid", if_id_valid, 0);
      check("stall_pending", fetch_pending, (i < 2) ? 1 : 0);
    end
    StallD = 1'b0;
    step();
    check("hold_next_addr", imem_addr, 32'h408);
    check("hold_req_stallf", imem_req, 0);

    // Redirect while waiting: stale response dropped
    StallF = 1'b0;
    step();
    id_branch_taken  = 1'b1;
    id_branch_target = 32'h0000_1000;
    step();
    id_branch_taken = 1'b0;
    check("redir_valid", if_id_valid, 0);
    check("redir_instr", if_id_instr, 32'h0);
    check("redir_pc", imem_addr, 32'h1000);
    check("redir_pending", fetch_pending, 1);
    step();
    check("redir_still_wait", fetch_pending, 1);
    lat = 1;
    exp_q.push_back({32'h2010_1401, 32'h0000_1004});
    step();
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h1000);
    check("redir_no_stale", if_id_valid, 0);
    step();
    StallF = 1'b1;
    step();

    // Branch under StallD ignored, then taken exactly once; low target bits cleared
    StallD           = 1'b1;
    id_branch_taken  = 1'b1;
    id_branch_target = 32'h0000_2003;
    step();
    check("stalled_branch_pc", imem_addr, 32'h1004);
    check("stalled_branch_ifid", if_id_instr, 32'h2010_1401);
    check("stalled_branch_valid", if_id_valid, 1);
    StallD = 1'b0;
    step();
    id_branch_taken = 1'b0;
    check("branch_once_pc", imem_addr, 32'h2000);
    check("branch_flush_valid", if_id_valid, 0);
    step();
    check("branch_once_pc_again", imem_addr, 32'h2000);

    // Memory not ready for 4 cycles: request held, bubbles into IF/ID
    StallF     = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("notready_req", imem_req, 1);
      check("notready_addr", imem_addr, 32'h2000);
      check("notready_valid", if_id_valid, 0);
      check("notready_instr", if_id_instr, 32'h0);
    end
    imem_ready = 1'b1;
    exp_q.push_back({32'h2010_2401, 32'h0000_2004});
    step();
    StallF = 1'b1;
    step();

    // PC+4 wraps at the top of the address space
    id_branch_taken  = 1'b1;
    id_branch_target = 32'hFFFF_FFFC;
    step();
    id_branch_taken = 1'b0;
    check("wrap_pc", imem_addr, 32'hFFFF_FFFC);
    StallF = 1'b0;
    exp_q.push_back({32'h2010_FBFD, 32'h0000_0000});
    step();
    StallF = 1'b1;
    step();
    check("wrap_next_pc", imem_addr, 32'h0);

    // Reset while waiting; the late response must be ignored
    lat    = 3;
    StallF = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midreset_req", imem_req, 0);
    check("midreset_valid", if_id_valid, 0);
    check("midreset_pending", fetch_pending, 0);
    check("midreset_pc", imem_addr, 32'h400);
    step();
    StallF = 1'b1;
    rst_n  = 1'b1;
    step();
    step();
    check("late_resp_valid", if_id_valid, 0);
    check("late_resp_pc", imem_addr, 32'h400);
    check("late_resp_pending", fetch_pending, 0);
    lat    = 1;
    StallF = 1'b0;
    exp_q.push_back({32'h2010_0001, 32'h0000_0404});
    step();
    StallF = 1'b1;
    step();
    step();
    step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
